// File: rtl/app_tst_seq.sv
// Test-sequence controller: timed enable of register engines, then gated per-channel data path.
// Optional watchdog on the RUN phase when APP_TST_WDOG_EN is defined (adds parameter WDOG_W).
module app_tst_seq #(
  parameter int CH_NUM     = 2,
  parameter int CNT_W      = 12,
  parameter int INIT_DLY   = 4010,
  parameter int STEP_DLY   = 1000,
  parameter int AUTO_START = 1
`ifdef APP_TST_WDOG_EN
  ,
  parameter int WDOG_W     = 24
`endif
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2*CH_NUM-1:0]   usr_lp_md_i,
  input  logic [CH_NUM-1:0]     h2c_run_i,
  input  logic [CH_NUM-1:0]     c2h_run_i,
  input  logic [CH_NUM-1:0]     dma_done_i,
  output logic                  usr_regrw_run_o,
  output logic                  cfg_regrw_run_o,
  output logic [CH_NUM-1:0]     dma_regrw_run_o,
  output logic [CH_NUM-1:0]     usr_h2c_run_o,
  output logic [CH_NUM-1:0]     usr_c2h_run_o,
  output logic [CH_NUM-1:0]     usr_lp_run_o,
  output logic [1:0]            seq_state_o,
  output logic                  seq_done_o,
  output logic                  tmo_o
);

  localparam int NSTG = CH_NUM + 3;
  localparam int SW   = $clog2(NSTG);
  localparam logic [CNT_W-1:0] INIT_TC = CNT_W'(INIT_DLY - 1);
  localparam logic [CNT_W-1:0] STEP_TC = CNT_W'(STEP_DLY - 1);
  localparam logic [SW-1:0]    LAST_STG = SW'(NSTG - 1);

  generate
    if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch
      $error("app_tst_seq: CH_NUM must be 1..8");
    end
    if (INIT_DLY < 1 || INIT_DLY > (2**CNT_W) - 1) begin : g_bad_init
      $error("app_tst_seq: INIT_DLY must be 1..2^CNT_W-1");
    end
    if (STEP_DLY < 1 || STEP_DLY > (2**CNT_W) - 1) begin : g_bad_step
      $error("app_tst_seq: STEP_DLY must be 1..2^CNT_W-1");
    end
`ifdef APP_TST_WDOG_EN
    if (WDOG_W < 2) begin : g_bad_wdog
      $error("app_tst_seq: WDOG_W must be at least 2");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam state_e RST_ST = (AUTO_START != 0) ? S_STEP : S_IDLE;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     stg_q, stg_d;
  // en_q[0]=usr, en_q[1]=cfg, en_q[2+k]=dma[k], en_q[NSTG-1]=data-path enable
  logic [NSTG-1:0]   en_q, en_d;
  logic [CNT_W-1:0]  tc;
  logic [CH_NUM-1:0] lp;
  logic              dp_en;

`ifdef APP_TST_WDOG_EN
  localparam logic [WDOG_W-1:0] WD_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
  logic [WDOG_W-1:0] wcnt_q, wcnt_d;
  logic              tmo_q, tmo_d;
`endif

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      stg_q   <= '0;
      en_q    <= '0;
`ifdef APP_TST_WDOG_EN
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      en_q    <= en_d;
`ifdef APP_TST_WDOG_EN
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    en_d    = en_q;
    tc      = (stg_q == '0) ? INIT_TC : STEP_TC;
`ifdef APP_TST_WDOG_EN
    wcnt_d  = '0;
    tmo_d   = tmo_q;
`endif
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      stg_d   = '0;
      en_d    = '0;
`ifdef APP_TST_WDOG_EN
      tmo_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d = S_STEP;
            cnt_d   = '0;
            stg_d   = '0;
            en_d    = '0;
`ifdef APP_TST_WDOG_EN
            tmo_d   = 1'b0;
`endif
          end
        end
        S_STEP: begin
          if (cnt_q == tc) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
              if (stg_q == SW'(k)) en_d[k] = 1'b1;
            end
            cnt_d = '0;
            if (stg_q == LAST_STG) state_d = S_RUN;
            else                   stg_d   = stg_q + SW'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
`ifdef APP_TST_WDOG_EN
          wcnt_d = wcnt_q + WDOG_W'(1);
`endif
          // completion takes priority over a coincident watchdog expiry
          if (&dma_done_i) begin
            state_d        = S_DONE;
            en_d[NSTG-1]   = 1'b0;
`ifdef APP_TST_WDOG_EN
          end else if (wcnt_q == WD_LAST) begin
            state_d        = S_DONE;
            en_d[NSTG-1]   = 1'b0;
            tmo_d          = 1'b1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dp_en           = en_q[NSTG-1];
  assign usr_regrw_run_o = en_q[0];
  assign cfg_regrw_run_o = en_q[1];
  assign dma_regrw_run_o = en_q[CH_NUM+1:2];
  assign seq_state_o     = state_q;
  assign seq_done_o      = (state_q == S_DONE);

  always_comb begin
    lp            = '0;
    usr_h2c_run_o = '0;
    usr_c2h_run_o = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      lp[i]            = &usr_lp_md_i[2*i +: 2];
      usr_h2c_run_o[i] = dp_en & ~lp[i] & h2c_run_i[i];
      usr_c2h_run_o[i] = dp_en & ~lp[i] & c2h_run_i[i];
    end
  end

  assign usr_lp_run_o = lp;

`ifdef APP_TST_WDOG_EN
  assign tmo_o = tmo_q;
`else
  assign tmo_o = 1'b0;
`endif

endmodule

// File: tb/tb_app_tst_seq.sv
// Bench for app_tst_seq: AUTO_START=1 and AUTO_START=0 instances share stimulus and are
// checked every cycle against a time-since-entry model, plus directed literal expectations.
module tb_app_tst_seq;

  localparam int CH   = 2;
  localparam int INIT = 10;
  localparam int STEP = 4;
  localparam int LAST_T = INIT + (CH + 2) * STEP;
`ifdef APP_TST_WDOG_EN
  localparam bit WD   = 1'b1;
  localparam int WMAX = 15;
`else
  localparam bit WD   = 1'b0;
  localparam int WMAX = 0;
`endif

  logic clk, rst_n, start, abort;
  logic [2*CH-1:0] lp_md;
  logic [CH-1:0]   h2c_in, c2h_in, done_in;

  logic          a_usr, a_cfg, a_done, a_tmo, b_usr, b_cfg, b_done, b_tmo;
  logic [CH-1:0] a_dma, a_h2c, a_c2h, a_lp, b_dma, b_h2c, b_c2h, b_lp;
  logic [1:0]    a_st, b_st;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int s     = 0;

  app_tst_seq #(
    .CH_NUM(CH), .CNT_W(12), .INIT_DLY(INIT), .STEP_DLY(STEP), .AUTO_START(1)
`ifdef APP_TST_WDOG_EN
    , .WDOG_W(4)
`endif
  ) dut_a (
    .usr_clk(clk), .usr_rst_n(rst_n), .start_i(start), .abort_i(abort),
    .usr_lp_md_i(lp_md), .h2c_run_i(h2c_in), .c2h_run_i(c2h_in), .dma_done_i(done_in),
    .usr_regrw_run_o(a_usr), .cfg_regrw_run_o(a_cfg), .dma_regrw_run_o(a_dma),
    .usr_h2c_run_o(a_h2c), .usr_c2h_run_o(a_c2h), .usr_lp_run_o(a_lp),
    .seq_state_o(a_st), .seq_done_o(a_done), .tmo_o(a_tmo)
  );

  app_tst_seq #(
    .CH_NUM(CH), .CNT_W(12), .INIT_DLY(INIT), .STEP_DLY(STEP), .AUTO_START(0)
`ifdef APP_TST_WDOG_EN
    , .WDOG_W(4)
`endif
  ) dut_b (
    .usr_clk(clk), .usr_rst_n(rst_n), .start_i(start), .abort_i(abort),
    .usr_lp_md_i(lp_md), .h2c_run_i(h2c_in), .c2h_run_i(c2h_in), .dma_done_i(done_in),
    .usr_regrw_run_o(b_usr), .cfg_regrw_run_o(b_cfg), .dma_regrw_run_o(b_dma),
    .usr_h2c_run_o(b_h2c), .usr_c2h_run_o(b_c2h), .usr_lp_run_o(b_lp),
    .seq_state_o(b_st), .seq_done_o(b_done), .tmo_o(b_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase (0 idle,1 step,2 run,3 done), cycles since STEP entry, cycles since RUN entry
  int m_st[2], m_t[2], m_rt[2];
  bit m_tmo[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = (i == 0) ? 1 : 0; m_t[i] = 0; m_rt[i] = 0; m_tmo[i] = 1'b0;
      end else if (abort) begin
        m_st[i] = 0; m_tmo[i] = 1'b0;
      end else begin
        case (m_st[i])
          0: if (start) begin m_st[i] = 1; m_t[i] = 0; end
          1: begin
            m_t[i]++;
            if (m_t[i] == LAST_T) begin m_st[i] = 2; m_rt[i] = 0; end
          end
          2: begin
            m_rt[i]++;
            if (&done_in) m_st[i] = 3;
            else if (WD && m_rt[i] == WMAX) begin m_st[i] = 3; m_tmo[i] = 1'b1; end
          end
          default: if (start) begin m_st[i] = 1; m_t[i] = 0; m_tmo[i] = 1'b0; end
        endcase
      end
    end
  end

  function automatic bit stage_on(int i, int k);
    if (m_st[i] == 2 || m_st[i] == 3) return 1'b1;
    return (m_st[i] == 1) && (m_t[i] >= INIT + k * STEP);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic usr, input logic cfg, input logic [CH-1:0] dma,
                     input logic [CH-1:0] h2c, input logic [CH-1:0] c2h, input logic [CH-1:0] lp,
                     input logic [1:0] st, input logic dn, input logic tm);
    logic [CH-1:0] e_dma, e_h2c, e_c2h, e_lp;
    bit dp;
    dp = (m_st[i] == 2);
    for (int j = 0; j < CH; j++) begin
      e_dma[j] = stage_on(i, 2 + j);
      e_lp[j]  = lp_md[2*j] & lp_md[2*j+1];
      e_h2c[j] = dp & !e_lp[j] & h2c_in[j];
      e_c2h[j] = dp & !e_lp[j] & c2h_in[j];
    end
    chk($sformatf("m%0d_usr", i), 32'(usr), 32'(stage_on(i, 0)));
    chk($sformatf("m%0d_cfg", i), 32'(cfg), 32'(stage_on(i, 1)));
    chk($sformatf("m%0d_dma", i), 32'(dma), 32'(e_dma));
    chk($sformatf("m%0d_h2c", i), 32'(h2c), 32'(e_h2c));
    chk($sformatf("m%0d_c2h", i), 32'(c2h), 32'(e_c2h));
    chk($sformatf("m%0d_lp", i),  32'(lp),  32'(e_lp));
    chk($sformatf("m%0d_state", i), 32'(st), 32'(m_st[i]));
    chk($sformatf("m%0d_done", i), 32'(dn), 32'(m_st[i] == 3));
    chk($sformatf("m%0d_tmo", i), 32'(tm), 32'(m_tmo[i]));
  endtask

  always @(posedge clk) begin
    #2;
    cmp(0, a_usr, a_cfg, a_dma, a_h2c, a_c2h, a_lp, a_st, a_done, a_tmo);
    cmp(1, b_usr, b_cfg, b_dma, b_h2c, b_c2h, b_lp, b_st, b_done, b_tmo);
  end

  task automatic tick();
    @(posedge clk);
    #3;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    lp_md = '0; h2c_in = '0; c2h_in = '0; done_in = '0;
    repeat (3) tick();
    chk("rst_a_state", 32'(a_st), 32'd1);
    chk("rst_b_state", 32'(b_st), 32'd0);
    chk("rst_a_usr", 32'(a_usr), 32'd0);

    rst_n = 1'b1; cyc = 0;
    wait_to(9);  chk("a_usr_c9", 32'(a_usr), 32'd0);
    tick();      chk("a_usr_c10", 32'(a_usr), 32'd1);
    wait_to(13); chk("a_cfg_c13", 32'(a_cfg), 32'd0);
    tick();      chk("a_cfg_c14", 32'(a_cfg), 32'd1);
    wait_to(18); chk("a_dma_c18", 32'(a_dma), 32'b01);
    wait_to(22); chk("a_dma_c22", 32'(a_dma), 32'b11);
    wait_to(25); chk("a_state_c25", 32'(a_st), 32'd1);
    tick();      chk("a_state_c26", 32'(a_st), 32'd2);

    lp_md = 4'b1100; h2c_in = 2'b11; c2h_in = 2'b11;
    tick();
    chk("a_h2c_lp", 32'(a_h2c), 32'b01);
    chk("a_c2h_lp", 32'(a_c2h), 32'b01);
    chk("a_lp_run", 32'(a_lp), 32'b10);
    chk("b_h2c_idle", 32'(b_h2c), 32'b00);

    done_in = 2'b01; repeat (3) tick();
    chk("a_run_partial_done", 32'(a_st), 32'd2);
    done_in = 2'b11; tick();
    chk("a_state_done", 32'(a_st), 32'd3);
    chk("a_seq_done", 32'(a_done), 32'd1);
    chk("a_h2c_done", 32'(a_h2c), 32'b00);

    wait_to(100);
    chk("b_idle_c100", 32'(b_st), 32'd0);
    chk("b_usr_c100", 32'(b_usr), 32'd0);
    chk("b_lp_c100", 32'(b_lp), 32'b10);

    lp_md = '0; h2c_in = 2'b11; c2h_in = 2'b11; done_in = '0;
    pulse_start(); s = cyc;
    chk("a_restart_state", 32'(a_st), 32'd1);
    chk("a_restart_dma", 32'(a_dma), 32'd0);
    chk("b_start_state", 32'(b_st), 32'd1);
    wait_to(s + 5); pulse_start();
    wait_to(s + 9); chk("a_usr_r9", 32'(a_usr), 32'd0);
    tick();         chk("a_usr_r10", 32'(a_usr), 32'd1);
    wait_to(s + 26);
    chk("a_run_r26", 32'(a_st), 32'd2);
    chk("b_run_r26", 32'(b_st), 32'd2);
    chk("a_h2c_r26", 32'(a_h2c), 32'b11);
    pulse_start();
    chk("b_start_in_run", 32'(b_st), 32'd2);
    done_in = 2'b11; tick();
    chk("b_done", 32'(b_done), 32'd1);

    pulse_start(); s = cyc; done_in = '0;
    wait_to(s + 16);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("a_abort_state", 32'(a_st), 32'd0);
    chk("a_abort_cfg", 32'(a_cfg), 32'd0);
    chk("b_abort_usr", 32'(b_usr), 32'd0);
    wait_to(s + 19); pulse_start();
    wait_to(s + 29); chk("a_usr_a29", 32'(a_usr), 32'd0);
    tick();          chk("a_usr_a30", 32'(a_usr), 32'd1);

    wait_to(s + 36);
    rst_n = 1'b0; #1;
    chk("a_async_rst_usr", 32'(a_usr), 32'd0);
    chk("a_async_rst_state", 32'(a_st), 32'd1);
    chk("b_async_rst_state", 32'(b_st), 32'd0);
    tick(); rst_n = 1'b1; cyc = 0;
    wait_to(10);
    chk("a_usr_rel10", 32'(a_usr), 32'd1);
    chk("b_state_rel10", 32'(b_st), 32'd0);

`ifdef APP_TST_WDOG_EN
    wait_to(26); chk("w_run_entry", 32'(a_st), 32'd2);
    wait_to(40);
    chk("w_state_40", 32'(a_st), 32'd2);
    chk("w_tmo_40", 32'(a_tmo), 32'd0);
    tick();
    chk("w_state_41", 32'(a_st), 32'd3);
    chk("w_tmo_41", 32'(a_tmo), 32'd1);
    pulse_start(); s = cyc;
    chk("w_tmo_cleared", 32'(a_tmo), 32'd0);
    wait_to(s + 40); done_in = 2'b11; tick();
    chk("w_tie_state", 32'(a_st), 32'd3);
    chk("w_tie_tmo", 32'(a_tmo), 32'd0);
    done_in = '0;
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/app_tst_seq.md
Name: app_tst_seq

Overview:
- Parametrised test-sequence controller for the SGDMA application layer; successor to the fixed-schedule test control block.
- After reset or on command, it enables the register-access engines and then the per-channel DMA register engines in a timed sequence.
- It then gates the per-channel H2C/C2H data-path runs, with per-channel loopback override.
- It tracks completion and reports status. Supports CH_NUM channels, a programmable schedule, restart and abort.

Parameters:
- CH_NUM, 2, number of DMA channels (1..8).
- CNT_W, 12, width of the step counter.
- INIT_DLY, 4010, cycles before stage 0 fires; 1..2^CNT_W-1.
- STEP_DLY, 1000, cycles between successive stages; 1..2^CNT_W-1.
- AUTO_START, 1, 1 = sequence starts on reset release; 0 = wait for start_i.

Ports:
- usr_clk, input, 1, user clock; all logic is on its rising edge.
- usr_rst_n, input, 1, reset, asynchronous, active-low.
- start_i, input, 1, single-cycle pulse: start the sequence (honoured only in IDLE or DONE).
- abort_i, input, 1, synchronous abort; returns to IDLE.
- usr_lp_md_i, input, 2*CH_NUM, loopback mode, 2 bits per channel; 2'b11 = loopback.
- h2c_run_i, input, CH_NUM, per-channel H2C request from the AXIS master.
- c2h_run_i, input, CH_NUM, per-channel C2H request from the AXIS slave.
- dma_done_i, input, CH_NUM, per-channel completion level.
- usr_regrw_run_o, output, 1, user register read/write engine enable.
- cfg_regrw_run_o, output, 1, config register read/write engine enable.
- dma_regrw_run_o, output, CH_NUM, per-channel DMA register engine enable.
- usr_h2c_run_o, output, CH_NUM, per-channel H2C write run.
- usr_c2h_run_o, output, CH_NUM, per-channel C2H read run.
- usr_lp_run_o, output, CH_NUM, per-channel loopback run.
- seq_state_o, output, 2, state: 0 = IDLE, 1 = STEP, 2 = RUN, 3 = DONE.
- seq_done_o, output, 1, high in DONE.
- tmo_o, output, 1, watchdog timeout flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - Counter 0, stage index 0.
  - State is STEP if AUTO_START = 1, otherwise IDLE.
- Stages, in order:
  - Stage 0: usr_regrw_run_o.
  - Stage 1: cfg_regrw_run_o.
  - Stages 2..CH_NUM+1: dma_regrw_run_o[k-2].
  - Stage CH_NUM+2: dp_en (data-path enable). Total NSTG = CH_NUM+3.
- STEP state:
  - The counter increments every cycle.
  - Terminal count is INIT_DLY-1 for stage 0 and STEP_DLY-1 for all other stages.
  - At terminal count, the stage's enable is set on that clock edge, the counter clears, and the stage index increments.
  - After the last stage, the state moves to RUN.
  - Stage 0's output goes high INIT_DLY cycles after entering STEP; stage k≥1 goes high INIT_DLY + k*STEP_DLY cycles after entry.
- Enables are sticky: once set they stay high until abort_i, start_i (restart) or reset.
- Data path, combinational from registered state:
  - lp[i] = &usr_lp_md_i[2i+1:2i].
  - usr_lp_run_o[i] = lp[i], independent of state.
  - usr_h2c_run_o[i] = dp_en & ~lp[i] & h2c_run_i[i].
  - usr_c2h_run_o[i] = dp_en & ~lp[i] & c2h_run_i[i].
- RUN state: when &dma_done_i == 1 on a clock edge, the next state is DONE and dp_en clears. The register-engine enables stay high.
- DONE state: seq_done_o = 1. A start_i pulse clears all enables, the counter and the stage index, then enters STEP.
- IDLE state: only start_i is honoured; it enters STEP with counter 0.
- start_i in STEP or RUN is ignored.
- abort_i in any state: the next state is IDLE; all enables, dp_en, seq_done_o and tmo_o clear on that edge.
- abort_i and start_i in the same cycle: abort wins, state stays IDLE.
- Asserting usr_rst_n low mid-sequence: immediate return to reset values, including AUTO_START behaviour on release.
- Counter never wraps: it clears at terminal count. INIT_DLY and STEP_DLY of 0 are illegal; an elaboration check fails them.

Optional Feature:
- APP_TST_WDOG_EN defined:
  - Adds parameter WDOG_W (default 24) and a RUN-state cycle counter that clears on RUN entry.
  - If the counter reaches 2^WDOG_W-1 before all done bits are high, the next state is DONE with tmo_o = 1.
  - tmo_o clears on start_i, abort_i or reset.
  - If done and timeout occur in the same cycle, done wins and tmo_o stays 0.
- APP_TST_WDOG_EN not defined: tmo_o is tied to 0, and RUN waits indefinitely for done.

Test Plan:
- CH_NUM=2, INIT_DLY=10, STEP_DLY=4, AUTO_START=1, reset release -> usr_regrw high at cycle 10, cfg at 14, dma[0] at 18, dma[1] at 22, dp_en/RUN at 26; seq_state_o = 2.
- RUN with usr_lp_md_i = 4'b1100, h2c_run_i = c2h_run_i = 2'b11 -> usr_h2c_run_o = usr_c2h_run_o = 2'b01, usr_lp_run_o = 2'b10.
- RUN, dma_done_i 2'b01 then 2'b11 -> DONE one cycle after 2'b11, seq_done_o = 1, h2c/c2h runs 0; start_i -> all enables 0, STEP, sequence repeats with identical timing.
- abort_i at cycle 16 (mid-STEP) with start_i also high -> IDLE at 17, all outputs 0; start_i at 20 -> usr_regrw high at 30.
- AUTO_START=0: reset release, no start for 100 cycles -> IDLE, outputs 0; start_i in RUN -> ignored.
- APP_TST_WDOG_EN, WDOG_W=4, dma_done_i held 0 -> DONE with tmo_o = 1 exactly 15 cycles after RUN entry.
